// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// Holds the debounce FSM state encoding and the default debounce length.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    localparam int DB_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, press/release debounce FSM,
// registered one-cycle press pulse and registered debounced level.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   btn   : raw asynchronous button input (may bounce)
//   pulse : one-cycle pulse per accepted press
//   level : debounced button level
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse,
    output logic level
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    btn_state_t    state;
    btn_state_t    state_n;
    logic          pulse_n;
    logic          level_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
            pulse <= 1'b0;
            level <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            cnt   <= cnt_n;
            state <= state_n;
            pulse <= pulse_n;
            level <= level_n;
        end
    end

    // The counter is cleared on every transition and saturates at
    // CNT_LAST, because a transition is always taken on reaching it.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (s2) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    pulse_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HELD: begin
                if (!s2) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Level is registered from the next state so it moves on the
        // same edge as the accepting transition.
        level_n = (state_n == HELD) || (state_n == RELEASE_WAIT);
    end

endmodule

// File: rtl/btn_conditioner.sv
// Two independent debounced button channels feeding the FSM X/Y inputs.
//   CLK, RST   : clock, asynchronous active-high reset
//   BTNX, BTNY : raw bouncing buttons
//   X, Y       : one-cycle press pulses
//   XL, YL     : debounced levels
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTNX,
    input  logic BTNY,
    output logic X,
    output logic Y,
    output logic XL,
    output logic YL
);

    debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_x (
        .clk   (CLK),
        .rst   (RST),
        .btn   (BTNX),
        .pulse (X),
        .level (XL)
    );

    debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_y (
        .clk   (CLK),
        .rst   (RST),
        .btn   (BTNY),
        .pulse (Y),
        .level (YL)
    );

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: run-length reference model
// checked every cycle, plus literal timing checks from the test plan.
module tb_btn_conditioner;

    localparam int DB = 4;

    logic CLK = 1'b0;
    logic RST;
    logic BTNX = 1'b0;
    logic BTNY = 1'b0;
    logic X, Y, XL, YL;

    int pass_cnt = 0;
    int total    = 0;

    btn_conditioner #(.DB_CYCLES(DB)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .BTNX (BTNX),
        .BTNY (BTNY),
        .X    (X),
        .Y    (Y),
        .XL   (XL),
        .YL   (YL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %b expected %b",
                      name, $time, act, exp);
    endtask

    // Reference model: the FSM sees the raw input two edges late; the
    // level flips once DB+1 consecutive seen samples disagree with it,
    // and a press pulse accompanies each 0->1 flip.
    logic [1:0] hist [2] = '{2'b00, 2'b00};
    logic       ml   [2] = '{1'b0, 1'b0};
    logic       mp   [2] = '{1'b0, 1'b0};
    int         run  [2] = '{0, 0};

    always @(posedge CLK or posedge RST) begin
        logic raw [2];
        logic s;
        raw[0] = BTNX;
        raw[1] = BTNY;
        for (int c = 0; c < 2; c++) begin
            if (RST) begin
                hist[c] = 2'b00;
                ml[c]   = 1'b0;
                mp[c]   = 1'b0;
                run[c]  = 0;
            end else begin
                s       = hist[c][1];
                hist[c] = {hist[c][0], raw[c]};
                mp[c]   = 1'b0;
                if (s == ml[c]) begin
                    run[c] = 0;
                end else begin
                    run[c]++;
                    if (run[c] == DB + 1) begin
                        ml[c]  = ~ml[c];
                        mp[c]  = ml[c];
                        run[c] = 0;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        chk("model_X",  X,  mp[0]);
        chk("model_Y",  Y,  mp[1]);
        chk("model_XL", XL, ml[0]);
        chk("model_YL", YL, ml[1]);
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic settle(input int n);
        BTNX = 1'b0;
        BTNY = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        RST  = 1'b1;
        BTNX = 1'b1;
        BTNY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_X",  X,  1'b0);
            chk("rst_Y",  Y,  1'b0);
            chk("rst_XL", XL, 1'b0);
            chk("rst_YL", YL, 1'b0);
        end
        RST = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            step();
            chk("post_rst_X",  X,  1'(i == 6));
            chk("post_rst_XL", XL, 1'(i >= 6));
            chk("post_rst_Y",  Y,  1'(i == 6));
        end
        settle(15);

        // Clean press: high for edges 0..19.
        BTNX = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            step();
            chk("clean_X",  X,  1'(i == 6));
            chk("clean_XL", XL, 1'(i >= 6 && i < 26));
            if (i == 19) BTNX = 1'b0;
        end
        settle(5);

        // Press bounce: 2 high, 2 low, for 12 edges.
        for (int i = 0; i < 20; i++) begin
            BTNX = (i < 12) ? 1'((i / 2) % 2 == 0) : 1'b0;
            step();
            chk("pbounce_X",  X,  1'b0);
            chk("pbounce_XL", XL, 1'b0);
        end
        settle(5);

        // Release bounce while held.
        BTNX = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("rbounce_held", XL, 1'b1);
        BTNX = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 1) BTNX = 1'b1;
            chk("rbounce_X",  X,  1'b0);
            chk("rbounce_XL", XL, 1'b1);
        end
        settle(15);
        chk("rbounce_done", XL, 1'b0);

        // Simultaneous presses.
        BTNX = 1'b1;
        BTNY = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            step();
            chk("simul_X", X, 1'(i == 6));
            chk("simul_Y", Y, 1'(i == 6));
        end
        settle(15);

        // Y three edges behind X.
        BTNX = 1'b1;
        for (int i = 0; i <= 14; i++) begin
            step();
            if (i == 2) BTNY = 1'b1;
            chk("skew_X",  X,  1'(i == 6));
            chk("skew_Y",  Y,  1'(i == 9));
            chk("skew_YL", YL, 1'(i >= 9));
        end
        settle(15);

        // Reset four edges into a press, released after two.
        BTNX = 1'b1;
        for (int i = 0; i < 4; i++) step();
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("midrst_X",  X,  1'b0);
            chk("midrst_XL", XL, 1'b0);
        end
        RST = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            step();
            chk("midrst_post_X",  X,  1'(i == 6));
            chk("midrst_post_XL", XL, 1'(i >= 6));
        end
        settle(15);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
